vga_captura: RTL and testbench
==============================

# vga_captura

Frame-capture receiver for the VGA link: samples a 640x480 VGA pixel stream (hsync, vsync, n_blank, 24-bit RGB) on the pixel clock and writes one complete frame, pixel by pixel, into video RAM through a linear write port. It is the receiving end of the VGA output path. It sits beside the display controller for loopback self-test and frame grab. Capture is armed by a start pulse and reports done or error.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- ADDR_WIDTH, 32, write address width
- BASE_ADDR, 0, RAM address of pixel (0,0)

- clock_25  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  pulse; arms capture of the next full frame
- hsync_in  in  1  horizontal sync, active-low
- vsync_in  in  1  vertical sync, active-low
- n_blank_in  in  1  1 = active pixel
- red_in, green_in, blue_in  in  8 each  pixel colour
- address  out  ADDR_WIDTH  RAM write address
- data_out  out  24  {red, green, blue}
- we  out  1  RAM write enable, one pixel per cycle
- busy  out  1  capture armed or running
- done  out  1  one-cycle pulse: frame captured
- error  out  1  sticky: malformed frame seen
- pixel_x, pixel_y  out  10 each  coordinates of the pixel being written

## Operation
- Inputs pass through one register stage (_r) before any decision. Edges are detected on the registered signals.
- Frame boundary: vsync_r falling edge (1->0). Line end: n_blank_r falling edge.
- FSM states: IDLE, ARM, CAPTURE, DONE.
  - IDLE: busy=0. On start=1: clear error and go to ARM. Otherwise stay.
  - ARM: busy=1. On a vsync falling edge: zero x, y and pixel count, then go to CAPTURE.
  - CAPTURE: busy=1.
    - Each cycle with n_blank_r=1 and x<H_ACTIVE, write one pixel: address = BASE_ADDR + count, data_out = {r,g,b}_r. Then count++ and x++.
    - On an n_blank falling edge: if x != H_ACTIVE, set error and go to IDLE. Otherwise x=0 and y++.
    - After the last write (count = H_ACTIVE*V_ACTIVE-1 written), go to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Error conditions. Each one sets error, stops writing and returns to IDLE:
  - vsync falling edge while in CAPTURE (short frame);
  - n_blank_r=1 while x=H_ACTIVE (long line); the write is suppressed in that case;
  - bad line length, as above.
- start is ignored in ARM, CAPTURE and DONE. start together with reset: reset wins.
- Address arithmetic is unsigned and ADDR_WIDTH wide. The pixel count is 19 bits, zero-extended. No wrap occurs within one frame.
- hsync_in is sampled only for the optional line count check. Line structure is taken from n_blank.

## Timing
- Reset values: address=BASE_ADDR, data_out=0, we=0, busy=0, done=0, error=0, pixel_x=0, pixel_y=0, FSM=IDLE.
- Latency: pixel on the inputs at edge t is seen by the input register at t. address, data_out, we, pixel_x and pixel_y are registered and valid after edge t+1.
- Throughput: one write per clock while n_blank is high. No back-pressure; the RAM must accept every cycle.
- The vsync edge is detected one cycle after the registered fall. The first active pixel of that frame is captured.
- done asserts in the cycle after the final we=1 cycle.
- error rises in the cycle after the offending edge or sample. It holds until the next accepted start.
- reset mid-frame: all outputs return to their reset values at the next edge. No partial write completes.

## Structure
- Package vga_pkg holds:
  - H_ACTIVE/V_ACTIVE defaults;
  - sync polarity constants (HSYNC_ACTIVE=0, VSYNC_ACTIVE=0);
  - the typedef enum for the FSM states (IDLE, ARM, CAPTURE, DONE);
  - the pixel typedef (struct of three 8-bit channels).
- Sub-module detector_flanco: registered edge detector producing rise and fall pulses. It is instantiated for vsync_r and n_blank_r.

## Test plan
- Bench parameters: H_ACTIVE=8, V_ACTIVE=4, BASE_ADDR=0x100.
- Clean frame after start: 32 writes, addresses 0x100..0x11F, data equal to the driven ramp 0x000000..0x00001F, then done=1 for one cycle and error=0.
- start pulsed mid-frame: no writes until the next vsync fall, then a full 32-write frame.
- Line 2 with 7 active pixels: error=1 one cycle after the n_blank fall, we stays 0 afterwards, done never asserts.
- Line with 9 active pixels: 9th pixel not written, error=1, FSM returns to IDLE.
- vsync fall after 20 writes: error=1, busy=0. A new start then captures the next frame cleanly and clears error.
- reset asserted during CAPTURE (write 10): next cycle we=0, busy=0, address=0x100. start pulses during busy are ignored.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame-capture receiver.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  // Both syncs are active-low on this link.
  localparam logic HSYNC_ACTIVE = 1'b0;
  localparam logic VSYNC_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StCapture,
    StDone
  } cap_state_e;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } pixel_t;

endpackage

// File: rtl/detector_flanco.sv
// Edge detector: keeps the previous sample and flags rising/falling transitions.
module detector_flanco #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q, sig_d;

  // Next previous-sample value is simply the current input.
  always_comb begin
    sig_d = sig_i;
  end

  // Previous-sample register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_q <= ResetVal;
    end else begin
      sig_q <= sig_d;
    end
  end

  // Pulses are valid in the cycle the new level is first present.
  always_comb begin
    rise_o = sig_i & ~sig_q;
    fall_o = ~sig_i & sig_q;
  end

endmodule

// File: rtl/vga_captura.sv
// Captures one 640x480 (parameterisable) VGA frame into RAM through a linear write port.
module vga_captura
  import vga_pkg::*;
#(
  parameter int unsigned             H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned             V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned             ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0
) (
  input  logic                  clock_25,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  n_blank_in,
  input  logic [7:0]            red_in,
  input  logic [7:0]            green_in,
  input  logic [7:0]            blue_in,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [23:0]           data_out,
  output logic                  we,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [9:0]            pixel_x,
  output logic [9:0]            pixel_y
);

  localparam logic [9:0]  HMax    = 10'(H_ACTIVE);
  localparam logic [18:0] LastCnt = 19'(H_ACTIVE * V_ACTIVE - 1);

  // Input register stage
  logic   hsync_r, vsync_r, n_blank_r;
  pixel_t rgb_r;

  // Edge pulses on the registered syncs
  logic vs_rise, vs_fall, nb_fall;
  logic unused_nb_rise;
  logic unused_hsync;
  logic frame_start;

  cap_state_e            state_q, state_d;
  logic [9:0]            x_q, x_d, y_q, y_d, px_q, px_d, py_q, py_d;
  logic [18:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  pixel_t                data_q, data_d;
  logic                  we_q, we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  detector_flanco #(.ResetVal(1'b1)) u_det_vsync (
    .clk_i  (clock_25),
    .rst_i  (reset),
    .sig_i  (vsync_r),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  detector_flanco #(.ResetVal(1'b0)) u_det_nblank (
    .clk_i  (clock_25),
    .rst_i  (reset),
    .sig_i  (n_blank_r),
    .rise_o (unused_nb_rise),
    .fall_o (nb_fall)
  );

  // Frame boundary is entry into the active vsync level; hsync is not used for line structure.
  always_comb begin
    frame_start  = (VSYNC_ACTIVE == 1'b0) ? vs_fall : vs_rise;
    unused_hsync = hsync_r ^ HSYNC_ACTIVE;
  end

  // Capture FSM next-state and write-port generation.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    px_d    = px_q;
    py_d    = py_q;
    err_d   = err_q;
    we_d    = 1'b0;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d   = 1'b0;
          state_d = StArm;
        end
      end
      StArm: begin
        if (frame_start) begin
          x_d     = '0;
          y_d     = '0;
          cnt_d   = '0;
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (frame_start) begin
          // Short frame
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (nb_fall) begin
          if (x_q != HMax) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            x_d = '0;
            y_d = y_q + 10'd1;
          end
        end else if (n_blank_r) begin
          if (x_q == HMax) begin
            // Long line: the extra pixel is dropped
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            we_d   = 1'b1;
            addr_d = BASE_ADDR + ADDR_WIDTH'(cnt_q);
            data_d = rgb_r;
            px_d   = x_q;
            py_d   = y_q;
            cnt_d  = cnt_q + 19'd1;
            x_d    = x_q + 10'd1;
            if (cnt_q == LastCnt) begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d == StArm) || (state_d == StCapture);
  end

  // Input stage and all state/output registers.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      hsync_r   <= 1'b1;
      vsync_r   <= 1'b1;
      n_blank_r <= 1'b0;
      rgb_r     <= '0;
      state_q   <= StIdle;
      x_q       <= '0;
      y_q       <= '0;
      cnt_q     <= '0;
      addr_q    <= BASE_ADDR;
      data_q    <= '0;
      px_q      <= '0;
      py_q      <= '0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      hsync_r   <= hsync_in;
      vsync_r   <= vsync_in;
      n_blank_r <= n_blank_in;
      rgb_r     <= '{red: red_in, green: green_in, blue: blue_in};
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      px_q      <= px_d;
      py_q      <= py_d;
      we_q      <= we_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Output drive from registers.
  always_comb begin
    address  = addr_q;
    data_out = data_q;
    we       = we_q;
    busy     = busy_q;
    done     = done_q;
    error    = err_q;
    pixel_x  = px_q;
    pixel_y  = py_q;
  end

endmodule

// File: tb/tb_vga_captura.sv
// Self-checking bench for vga_captura with a small 8x4 frame.
module tb_vga_captura;

  localparam int          H    = 8;
  localparam int          V    = 4;
  localparam logic [31:0] BASE = 32'h100;

  logic        clock_25 = 1'b0;
  logic        reset, start, hsync_in, vsync_in, n_blank_in;
  logic [7:0]  red_in, green_in, blue_in;
  logic [31:0] address;
  logic [23:0] data_out;
  logic        we, busy, done, error;
  logic [9:0]  pixel_x, pixel_y;

  vga_captura #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .ADDR_WIDTH (32),
    .BASE_ADDR  (BASE)
  ) dut (
    .clock_25   (clock_25),
    .reset      (reset),
    .start      (start),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .n_blank_in (n_blank_in),
    .red_in     (red_in),
    .green_in   (green_in),
    .blue_in    (blue_in),
    .address    (address),
    .data_out   (data_out),
    .we         (we),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y)
  );

  always #5 clock_25 = ~clock_25;

  typedef struct {
    logic [31:0] addr;
    logic [23:0] data;
    logic [9:0]  px;
    logic [9:0]  py;
  } wr_t;

  typedef struct {
    string name;
    int    start_mode;  // 0 none, 1 before frame, 2 during line 1
    int    bad_line;    // -1 for none
    int    bad_len;
    int    vs_after;    // active-pixel index carrying an early vsync, -1 for none
    bit    ramp;
    int    exp_writes;
    bit    exp_done;
    bit    exp_err;
    bit    exp_busy;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  wr_t         act_q[$];
  logic [23:0] drv_q[$];
  int          done_cnt, done_cyc, last_we_cyc, err_rise_cyc, mark_cyc;
  logic        err_prev = 1'b0;
  vec_t        tbl[7];

  always @(posedge clock_25) cyc <= cyc + 1;

  // Write monitor, sampled on the falling edge.
  always @(negedge clock_25) begin
    if (we) begin
      act_q.push_back('{addr: address, data: data_out, px: pixel_x, py: pixel_y});
      last_we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (error && !err_prev) err_rise_cyc = cyc;
    err_prev = error;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_25);
    #1;
  endtask

  task automatic set_pix(input logic [23:0] p);
    {red_in, green_in, blue_in} = p;
  endtask

  // Horizontal blanking with a short hsync pulse; length is randomised.
  task automatic line_gap();
    int n;
    n = int'($urandom_range(3, 5));
    n_blank_in = 1'b0;
    set_pix(24'h0);
    for (int i = 0; i < n; i++) begin
      hsync_in = (i == 1) ? 1'b0 : 1'b1;
      tick();
    end
    hsync_in = 1'b1;
  endtask

  task automatic clear_obs();
    act_q.delete();
    drv_q.delete();
    done_cnt     = 0;
    done_cyc     = -1;
    last_we_cyc  = -1;
    err_rise_cyc = -1;
    mark_cyc     = -1;
  endtask

  task automatic send_frame(input int start_mode, input int bad_line, input int bad_len,
                            input int vs_after, input bit ramp);
    int          n;
    int          len;
    bit          stop;
    logic [23:0] p;
    n    = 0;
    stop = 1'b0;
    n_blank_in = 1'b0;
    vsync_in   = 1'b1;
    set_pix(24'h0);
    for (int i = 0; i < 3; i++) begin
      start = (start_mode == 1 && i == 0);
      tick();
      start = 1'b0;
      if (start_mode == 1 && i == 0) check("start_clears_err", {31'd0, error}, 32'd0);
    end
    vsync_in = 1'b0;
    tick();
    tick();
    vsync_in = 1'b1;
    tick();
    tick();
    for (int l = 0; l < V; l++) begin
      len = (l == bad_line) ? bad_len : H;
      for (int k = 0; k < len; k++) begin
        p = ramp ? 24'(n) : 24'($urandom);
        drv_q.push_back(p);
        set_pix(p);
        n_blank_in = 1'b1;
        start      = (start_mode == 2 && l == 1 && k == 0);
        vsync_in   = (n == vs_after) ? 1'b0 : 1'b1;
        if (n == vs_after || (l == bad_line && bad_len > H && k == H)) mark_cyc = cyc;
        if (n == vs_after) stop = 1'b1;
        tick();
        start    = 1'b0;
        vsync_in = 1'b1;
        n++;
        if (stop) break;
      end
      n_blank_in = 1'b0;
      set_pix(24'h0);
      if (l == bad_line && bad_len < H) mark_cyc = cyc;
      if (stop) break;
      line_gap();
    end
    n_blank_in = 1'b0;
    vsync_in   = 1'b1;
    for (int i = 0; i < 5; i++) tick();
  endtask

  initial begin
    int c0;
    reset      = 1'b1;
    start      = 1'b0;
    hsync_in   = 1'b1;
    vsync_in   = 1'b1;
    n_blank_in = 1'b0;
    set_pix(24'h0);

    tbl[0] = '{"clean_ramp",   1, -1, 0, -1, 1'b1, 32, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{"start_mid",    2, -1, 0, -1, 1'b0,  0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{"after_mid",    0, -1, 0, -1, 1'b0, 32, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{"short_line",   1,  2, 7, -1, 1'b0, 23, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{"long_line",    1,  1, 9, -1, 1'b0, 16, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{"short_frame",  1, -1, 0, 20, 1'b0, 20, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{"clean_again",  1, -1, 0, -1, 1'b0, 32, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    tick();
    check("rst_address", address, BASE);
    check("rst_data", {8'd0, data_out}, 32'd0);
    check("rst_we", {31'd0, we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_px", {22'd0, pixel_x}, 32'd0);
    check("rst_py", {22'd0, pixel_y}, 32'd0);

    // Reset in the middle of a capture, with start pulses that must be ignored.
    clear_obs();
    start = 1'b1;
    tick();
    start    = 1'b0;
    vsync_in = 1'b0;
    tick();
    tick();
    vsync_in = 1'b1;
    tick();
    tick();
    for (int k = 0; k < H; k++) begin
      set_pix(24'($urandom));
      n_blank_in = 1'b1;
      start      = (k == 3);
      tick();
      start = 1'b0;
    end
    line_gap();
    check("busy_capture", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      set_pix(24'($urandom));
      n_blank_in = 1'b1;
      reset      = (k == 3);
      start      = (k == 3);
      tick();
    end
    reset      = 1'b0;
    start      = 1'b0;
    n_blank_in = 1'b0;
    check("mid_rst_writes", act_q.size(), 32'd10);
    check("mid_rst_we", {31'd0, we}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_address", address, BASE);
    check("mid_rst_data", {8'd0, data_out}, 32'd0);
    tick();
    check("rst_beats_start", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) tick();

    for (int r = 0; r < 7; r++) begin
      clear_obs();
      send_frame(tbl[r].start_mode, tbl[r].bad_line, tbl[r].bad_len, tbl[r].vs_after,
                 tbl[r].ramp);
      check({tbl[r].name, "_writes"}, act_q.size(), tbl[r].exp_writes);
      for (int i = 0; i < tbl[r].exp_writes && i < act_q.size(); i++) begin
        check({tbl[r].name, "_addr"}, act_q[i].addr, BASE + 32'(i));
        check({tbl[r].name, "_data"}, {8'd0, act_q[i].data}, {8'd0, drv_q[i]});
        check({tbl[r].name, "_px"}, {22'd0, act_q[i].px}, 32'(i % H));
        check({tbl[r].name, "_py"}, {22'd0, act_q[i].py}, 32'(i / H));
      end
      check({tbl[r].name, "_done"}, done_cnt, {31'd0, tbl[r].exp_done});
      check({tbl[r].name, "_error"}, {31'd0, error}, {31'd0, tbl[r].exp_err});
      check({tbl[r].name, "_busy"}, {31'd0, busy}, {31'd0, tbl[r].exp_busy});
      if (tbl[r].exp_done) begin
        check({tbl[r].name, "_done_time"}, done_cyc, last_we_cyc + 1);
      end
      if (tbl[r].exp_err) begin
        c0 = mark_cyc + 2;
        check({tbl[r].name, "_err_time"}, err_rise_cyc, c0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
